// File: rtl/lsu_writeback_if.sv
// Request/response bundle between the issue logic and the load/store writeback unit.
// The master drives the request fields; the slave (lsu_writeback) drives status and the write port.
interface lsu_writeback_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 3
);
    logic              start;
    logic              is_load;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dest_reg;

    logic              busy;
    logic              done;
    logic              wr_en;
    logic [REG_AW-1:0] write_addr;
    logic [DATA_W-1:0] write_val;

    modport master (
        output start,
        output is_load,
        output addr,
        output store_data,
        output dest_reg,
        input  busy,
        input  done,
        input  wr_en,
        input  write_addr,
        input  write_val
    );

    modport slave (
        input  start,
        input  is_load,
        input  addr,
        input  store_data,
        input  dest_reg,
        output busy,
        output done,
        output wr_en,
        output write_addr,
        output write_val
    );
endinterface

// File: rtl/lsu_writeback.sv
// Multi-cycle load/store unit with private data memory, driving the reg_file write port.
// Optional feature: define LSU_ZERO_R0_EN to suppress wr_en for loads targeting register 0.
module lsu_writeback #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int unsigned ACCESS_LAT = 2
) (
    input logic            clk,
    input logic            reset,
    lsu_writeback_if.slave bus
);

    localparam int unsigned IdxW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam int unsigned CntW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWb
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_load_q, is_load_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] wval_q, wval_d;

    logic              busy, done, wr_en;
    logic              mem_we;
    logic [IdxW-1:0]   addr_idx;

    // Not reset: contents survive a reset.
    logic [DATA_W-1:0] mem [DMEM_DEPTH];

    // Power-of-two depth, so truncation is the modulo wrap.
    assign addr_idx = IdxW'(addr_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            addr_q    <= '0;
            sdata_q   <= '0;
            dest_q    <= '0;
            wval_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            dest_q    <= dest_d;
            wval_q    <= wval_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_idx] <= sdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        dest_d    = dest_q;
        wval_d    = wval_q;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    is_load_d = bus.is_load;
                    addr_d    = bus.addr;
                    sdata_d   = bus.store_data;
                    dest_d    = bus.dest_reg;
                    cnt_d     = CntW'(ACCESS_LAT - 1);
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StWb;
                    if (is_load_q) begin
                        wval_d = mem[addr_idx];
                    end else begin
                        // A reset on this edge aborts the store.
                        mem_we = reset;
                    end
                end
            end
            StWb: begin
                busy    = 1'b1;
                done    = 1'b1;
`ifdef LSU_ZERO_R0_EN
                wr_en   = is_load_q && (dest_q != '0);
`else
                wr_en   = is_load_q;
`endif
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.wr_en      = wr_en;
    assign bus.write_addr = dest_q;
    assign bus.write_val  = wval_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback: directed scenarios then random traffic
// checked against an array-based memory model.
module tb_lsu_writeback;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    lsu_writeback_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    lsu_writeback #(
        .DATA_W    (DW),
        .REG_AW    (AW),
        .DMEM_DEPTH(DEPTH),
        .ACCESS_LAT(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_wval;
    logic [AW-1:0] ref_waddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.is_load    = 1'($urandom);
        bus.addr       = DW'($urandom);
        bus.store_data = DW'($urandom);
        bus.dest_reg   = AW'($urandom);
    endtask

    // Call #1 after a clock edge with the DUT idle.
    task automatic run_txn(input bit ld, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input logic [AW-1:0] r, input bit poke);
        int  n;
        bit  seen;
        bit  exp_wr;
        int  idx;
        idx = int'(a) % DEPTH;
`ifdef LSU_ZERO_R0_EN
        exp_wr = ld && (r != 0);
`else
        exp_wr = ld;
`endif
        bus.start      = 1'b1;
        bus.is_load    = ld;
        bus.addr       = a;
        bus.store_data = d;
        bus.dest_reg   = r;
        @(posedge clk);
        #1;
        if (poke) begin
            bus.start      = 1'b1;
            bus.is_load    = 1'b1;
            bus.addr       = 8'h20;
            bus.store_data = 8'h00;
            bus.dest_reg   = 3'd5;
        end else begin
            bus.start = 1'b0;
            scramble_inputs();
        end
        chk("busy_after_accept", bus.busy, 1);
        chk("done_after_accept", bus.done, 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < int'(LAT) + 8) begin
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("busy_in_access", bus.busy, 1);
                chk("wr_en_in_access", bus.wr_en, 0);
            end
        end
        chk("done_latency", n, LAT);
        ref_waddr = r;
        if (ld) begin
            ref_wval = ref_mem[idx];
        end else begin
            ref_mem[idx] = d;
        end
        if (seen) begin
            chk("wb_busy", bus.busy, 1);
            chk("wb_wr_en", bus.wr_en, exp_wr);
            chk("wb_write_addr", bus.write_addr, ref_waddr);
            if (ld) begin
                chk("wb_write_val", bus.write_val, ref_wval);
            end
        end
        @(posedge clk);
        #1;
        chk("post_done", bus.done, 0);
        chk("post_wr_en", bus.wr_en, 0);
        chk("post_busy", bus.busy, 0);
        chk("post_write_val", bus.write_val, ref_wval);
        chk("post_write_addr", bus.write_addr, ref_waddr);
    endtask

    // Reset lands on the edge that would have committed the store.
    task automatic reset_mid_store(input logic [DW-1:0] a, input logic [DW-1:0] d);
        bus.start      = 1'b1;
        bus.is_load    = 1'b0;
        bus.addr       = a;
        bus.store_data = d;
        bus.dest_reg   = 3'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", bus.busy, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ref_wval  = '0;
        ref_waddr = '0;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_wr_en", bus.wr_en, 0);
        chk("rst_mid_write_addr", bus.write_addr, 0);
        chk("rst_mid_write_val", bus.write_val, 0);
        reset = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        scramble_inputs();
        ref_wval  = '0;
        ref_waddr = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

        // Reset held for two edges
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_write_addr", bus.write_addr, 0);
        chk("rst_write_val", bus.write_val, 0);
        reset = 1'b1;

        // Store then load back
        run_txn(1'b0, 8'h10, 8'd42, 3'd1, 1'b0);
        run_txn(1'b1, 8'h10, 8'd0, 3'd3, 1'b0);
        chk("t2_write_val", bus.write_val, 42);
        chk("t2_write_addr", bus.write_addr, 3);

        // Start pulsed while busy is ignored
        run_txn(1'b0, 8'h05, 8'd99, 3'd2, 1'b1);
        run_txn(1'b1, 8'h05, 8'd0, 3'd6, 1'b0);
        chk("t3_mem05", bus.write_val, 99);

        // Reset during ACCESS drops the store; 0x30 wraps onto index 0 (holds 42)
        reset_mid_store(8'h30, 8'd77);
        run_txn(1'b1, 8'h30, 8'd0, 3'd1, 1'b0);
        chk("t4_abort_store", bus.write_val, 42);

        // Address wrap
        run_txn(1'b0, 8'h13, 8'hAB, 3'd0, 1'b0);
        run_txn(1'b1, 8'h03, 8'd0, 3'd4, 1'b0);
        chk("t5_wrap", bus.write_val, 8'hAB);

        // Load into r0
        run_txn(1'b0, 8'h00, 8'hFF, 3'd7, 1'b0);
        run_txn(1'b1, 8'h00, 8'd0, 3'd0, 1'b0);
        chk("t6_write_val", bus.write_val, 8'hFF);

        // Random traffic, every location written first
        for (int i = 0; i < int'(DEPTH); i++) begin
            run_txn(1'b0, DW'(i + int'(DEPTH) * $urandom_range(0, 15)), DW'($urandom),
                    AW'($urandom), 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), DW'($urandom), DW'($urandom), AW'($urandom),
                    1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
